// File: rtl/pll_lock_sequencer_pkg.sv
// rtl/pll_lock_sequencer_pkg.sv - state encoding, widths and sizing helper for the PLL lock sequencer
package pll_seq_pkg;

   localparam int STATE_W = 3;
   localparam int RETRY_W = 4;
   localparam int LOL_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      HOLD      = 3'd1,
      WAIT_LOCK = 3'd2,
      STABLE    = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - sequencer control/status bundle; lol_cnt exists only with PLL_SEQ_LOL_CNT_EN
interface pll_lock_sequencer_if;
   import pll_seq_pkg::*;

   logic               enable;
   logic               pll_locked;
   logic               pll_rst;
   logic               audio_rst;
   logic               ready;
   logic               fault;
   logic [RETRY_W-1:0] retry_cnt;
   logic [STATE_W-1:0] state_o;
`ifdef PLL_SEQ_LOL_CNT_EN
   logic [LOL_W-1:0]   lol_cnt;
`endif

   modport master (
      input  enable,
      input  pll_locked,
      output pll_rst,
      output audio_rst,
      output ready,
      output fault,
      output retry_cnt,
      output state_o
`ifdef PLL_SEQ_LOL_CNT_EN
      , output lol_cnt
`endif
   );

   modport slave (
      output enable,
      output pll_locked,
      input  pll_rst,
      input  audio_rst,
      input  ready,
      input  fault,
      input  retry_cnt,
      input  state_o
`ifdef PLL_SEQ_LOL_CNT_EN
      , input lol_cnt
`endif
   );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer, synchronous active-high reset to 0
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock qualification FSM with timeout retry; PLL_SEQ_LOL_CNT_EN adds lol_cnt
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES    = 16,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES        = 3
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_sequencer_if.master  bus
);

   localparam int CNT_W = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES)) + 1;
   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [RETRY_W-1:0] retry, retry_nxt;
   logic               lock_s;
   logic               pll_rst_q, audio_rst_q, ready_q, fault_q;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (bus.pll_locked),
      .q   (lock_s)
   );

   // One counter serves hold time, lock timeout and stability window; each user restarts it at 0.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry;
      if (!bus.enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = STABLE;
                  cnt_nxt   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_nxt = '0;
                  if (retry == RETRY_LIMIT) begin
                     state_nxt = FAULT;
                  end else begin
                     state_nxt = HOLD;
                     retry_nxt = retry + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_nxt = HOLD;
                  cnt_nxt   = '0;
                  retry_nxt = '0;
               end
            end
            FAULT: state_nxt = FAULT;
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as the state register.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         retry       <= '0;
         pll_rst_q   <= 1'b1;
         audio_rst_q <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         retry       <= retry_nxt;
         pll_rst_q   <= (state_nxt == IDLE) || (state_nxt == HOLD) || (state_nxt == FAULT);
         audio_rst_q <= (state_nxt != RUN);
         ready_q     <= (state_nxt == RUN);
         fault_q     <= (state_nxt == FAULT);
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.audio_rst = audio_rst_q;
   assign bus.ready     = ready_q;
   assign bus.fault     = fault_q;
   assign bus.retry_cnt = retry;
   assign bus.state_o   = state;

`ifdef PLL_SEQ_LOL_CNT_EN
   logic             lol_evt;
   logic [LOL_W-1:0] lol_q;

   assign lol_evt = bus.enable && (state == RUN) && !lock_s;

   always_ff @(posedge refclk) begin
      if (rst) begin
         lol_q <= '0;
      end else if (lol_evt && (lol_q != {LOL_W{1'b1}})) begin
         lol_q <= lol_q + 1'b1;
      end
   end

   assign bus.lol_cnt = lol_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed bench for pll_lock_sequencer at small timing parameters
module tb_pll_lock_sequencer;
   import pll_seq_pkg::*;

   logic refclk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   int   n;

   pll_lock_sequencer_if bus ();

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES    (4),
      .LOCK_TIMEOUT       (32),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.pll_locked = 1'b0;
      tick();
      tick();
      check("rst_state", bus.state_o, IDLE);
      check("rst_pll_rst", bus.pll_rst, 1);
      check("rst_audio_rst", bus.audio_rst, 1);
      check("rst_ready", bus.ready, 0);
      check("rst_fault", bus.fault, 0);
      check("rst_retry", bus.retry_cnt, 0);
`ifdef PLL_SEQ_LOL_CNT_EN
      check("rst_lol", bus.lol_cnt, 0);
`endif

      // Nominal bring-up
      rst = 1'b0;
      bus.enable = 1'b1;
      n = 0;
      tick();
      while (bus.pll_rst === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      check("nom_hold_len", n, 4);
      check("nom_wait_state", bus.state_o, WAIT_LOCK);
      check("nom_wait_audio_rst", bus.audio_rst, 1);
      repeat (9) tick();
      bus.pll_locked = 1'b1;
      tick();
      tick();
      check("nom_sync_latency", bus.state_o, WAIT_LOCK);
      tick();
      check("nom_stable_entry", bus.state_o, STABLE);
      repeat (7) tick();
      check("nom_stable_last", bus.state_o, STABLE);
      tick();
      check("nom_run_state", bus.state_o, RUN);
      check("nom_run_ready", bus.ready, 1);
      check("nom_run_audio_rst", bus.audio_rst, 0);
      check("nom_run_pll_rst", bus.pll_rst, 0);

      // Loss of lock in RUN
      bus.pll_locked = 1'b0;
      tick();
      tick();
      check("lol_still_ready", bus.ready, 1);
      tick();
      check("lol_state", bus.state_o, HOLD);
      check("lol_audio_rst", bus.audio_rst, 1);
      check("lol_ready", bus.ready, 0);
      check("lol_pll_rst", bus.pll_rst, 1);
      check("lol_retry", bus.retry_cnt, 0);
`ifdef PLL_SEQ_LOL_CNT_EN
      check("lol_cnt", bus.lol_cnt, 1);
`endif
      repeat (4) tick();
      check("lol_rewait", bus.state_o, WAIT_LOCK);
      repeat (31) tick();
      check("to1_last_cycle", bus.state_o, WAIT_LOCK);
      tick();
      check("to1_state", bus.state_o, HOLD);
      check("to1_retry", bus.retry_cnt, 1);
      repeat (4) tick();
      check("to1_rewait", bus.state_o, WAIT_LOCK);

      // Stability glitch: 5 high, 1 low, then high
      bus.pll_locked = 1'b1;
      repeat (3) tick();
      check("gl_stable", bus.state_o, STABLE);
      repeat (2) tick();
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      tick();
      check("gl_pre_drop", bus.state_o, STABLE);
      tick();
      check("gl_back_wait", bus.state_o, WAIT_LOCK);
      check("gl_retry_kept", bus.retry_cnt, 1);
      tick();
      check("gl_restable", bus.state_o, STABLE);
      repeat (7) tick();
      check("gl_stable_last", bus.state_o, STABLE);
      tick();
      check("gl_run", bus.state_o, RUN);
      check("gl_run_retry", bus.retry_cnt, 1);

      // Disable from RUN keeps retry_cnt
      bus.enable = 1'b0;
      bus.pll_locked = 1'b0;
      tick();
      check("dis_state", bus.state_o, IDLE);
      check("dis_pll_rst", bus.pll_rst, 1);
      check("dis_audio_rst", bus.audio_rst, 1);
      check("dis_ready", bus.ready, 0);
      check("dis_retry_kept", bus.retry_cnt, 1);

      // Lock arrives exactly on the last timeout cycle
      bus.enable = 1'b1;
      tick();
      check("bd_hold", bus.state_o, HOLD);
      check("bd_retry_clr", bus.retry_cnt, 0);
      repeat (4) tick();
      check("bd_wait", bus.state_o, WAIT_LOCK);
      repeat (29) tick();
      bus.pll_locked = 1'b1;
      tick();
      tick();
      check("bd_cnt31", bus.state_o, WAIT_LOCK);
      tick();
      check("bd_stable", bus.state_o, STABLE);
      check("bd_retry", bus.retry_cnt, 0);

      // Reset in STABLE
      rst = 1'b1;
      tick();
      check("r6_state", bus.state_o, IDLE);
      check("r6_pll_rst", bus.pll_rst, 1);
      check("r6_audio_rst", bus.audio_rst, 1);
      check("r6_ready", bus.ready, 0);
      check("r6_fault", bus.fault, 0);
      check("r6_retry", bus.retry_cnt, 0);
`ifdef PLL_SEQ_LOL_CNT_EN
      check("r6_lol", bus.lol_cnt, 0);
`endif

      // Disable in WAIT_LOCK
      rst = 1'b0;
      bus.pll_locked = 1'b0;
      tick();
      check("d6_hold", bus.state_o, HOLD);
      repeat (4) tick();
      check("d6_wait", bus.state_o, WAIT_LOCK);
      repeat (5) tick();
      bus.enable = 1'b0;
      tick();
      check("d6_state", bus.state_o, IDLE);
      check("d6_pll_rst", bus.pll_rst, 1);
      check("d6_audio_rst", bus.audio_rst, 1);
      check("d6_ready", bus.ready, 0);

      // Timeout/retry to FAULT
      bus.enable = 1'b1;
      tick();
      check("to_hold", bus.state_o, HOLD);
      check("to_retry0", bus.retry_cnt, 0);
      for (int a = 0; a < 3; a++) begin
         repeat (4) tick();
         check("to_wait", bus.state_o, WAIT_LOCK);
         check("to_retry", bus.retry_cnt, a);
         n = 0;
         while (bus.state_o === WAIT_LOCK && n < 100) begin
            n++;
            tick();
         end
         check("to_wait_len", n, 32);
         if (a < 2) begin
            check("to_rehold", bus.state_o, HOLD);
            check("to_retry_inc", bus.retry_cnt, a + 1);
         end
      end
      check("flt_state", bus.state_o, FAULT);
      check("flt_fault", bus.fault, 1);
      check("flt_pll_rst", bus.pll_rst, 1);
      check("flt_audio_rst", bus.audio_rst, 1);
      check("flt_retry", bus.retry_cnt, 2);
      repeat (10) tick();
      check("flt_sticky_state", bus.state_o, FAULT);
      check("flt_sticky_fault", bus.fault, 1);
      bus.enable = 1'b0;
      tick();
      check("flt_exit_state", bus.state_o, IDLE);
      check("flt_exit_fault", bus.fault, 0);
      check("flt_exit_retry", bus.retry_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
